// File: rtl/vx_hw_itr_ctrl_if.sv
// ---------------------------------------------------------------------------
// vx_hw_itr_ctrl_if
//
// Bundles every non-clock signal of the per-warp hardware interrupt
// controller, so the controller and its surroundings share one port.
//
// Signal groups:
//   itr_req_*     interrupt request (always accepted, coalesces into pending)
//   itr_enable    per-warp enable mask
//   take_*        redirect offer to the warp scheduler, valid/ready handshake;
//                 take_ret_pc is the resume PC captured on accept
//   ret_*         handler return committed by a warp
//   resume_*      one-cycle pulse carrying the saved return PC
//   ret_err       one-cycle pulse: return from a warp not in a handler
//   in_handler    per-warp "executing a handler" view
//   pending       per-warp OR of pending source bits
//
// Modports:
//   slave   the controller itself
//   master  the environment (sources, scheduler, commit)
// ---------------------------------------------------------------------------
interface vx_hw_itr_ctrl_if #(
    parameter int NUM_WARPS = 4,
    parameter int NUM_SRCS  = 4,
    parameter int XLEN      = 32
) ();

    localparam int WID_W = (NUM_WARPS > 1) ? $clog2(NUM_WARPS) : 1;
    localparam int SRC_W = (NUM_SRCS > 1) ? $clog2(NUM_SRCS) : 1;

    logic                 itr_req_valid;
    logic [WID_W-1:0]     itr_req_wid;
    logic [SRC_W-1:0]     itr_req_src;
    logic [NUM_WARPS-1:0] itr_enable;

    logic                 take_valid;
    logic [WID_W-1:0]     take_wid;
    logic [SRC_W-1:0]     take_src;
    logic [XLEN-1:0]      take_pc;
    logic                 take_ready;
    logic [XLEN-1:0]      take_ret_pc;

    logic                 ret_valid;
    logic [WID_W-1:0]     ret_wid;

    logic                 resume_valid;
    logic [WID_W-1:0]     resume_wid;
    logic [XLEN-1:0]      resume_pc;
    logic                 ret_err;

    logic [NUM_WARPS-1:0] in_handler;
    logic [NUM_WARPS-1:0] pending;

    modport slave (
        input  itr_req_valid, itr_req_wid, itr_req_src, itr_enable,
        input  take_ready, take_ret_pc,
        input  ret_valid, ret_wid,
        output take_valid, take_wid, take_src, take_pc,
        output resume_valid, resume_wid, resume_pc, ret_err,
        output in_handler, pending
    );

    modport master (
        output itr_req_valid, itr_req_wid, itr_req_src, itr_enable,
        output take_ready, take_ret_pc,
        output ret_valid, ret_wid,
        input  take_valid, take_wid, take_src, take_pc,
        input  resume_valid, resume_wid, resume_pc, ret_err,
        input  in_handler, pending
    );

endinterface

// File: rtl/vx_hw_itr_ctrl.sv
// ---------------------------------------------------------------------------
// vx_hw_itr_ctrl
//
// Per-warp hardware interrupt controller for the execute stage. Each warp
// owns a set of pending source bits, a small state machine
// (IDLE -> OFFERED -> HANDLER -> IDLE) and a saved return PC. Eligible
// warps are picked round-robin, the lowest pending source of the chosen
// warp is serviced first, and a single registered redirect offer is
// presented to the scheduler until it is accepted.
//
// Ports:
//   clk    clock
//   reset  asynchronous, active-low reset
//   bus    vx_hw_itr_ctrl_if.slave carrying requests, the take offer,
//          handler returns, resume/error pulses and the status views
// ---------------------------------------------------------------------------
module vx_hw_itr_ctrl #(
    parameter int              NUM_WARPS      = 4,
    parameter int              NUM_SRCS       = 4,
    parameter int              XLEN           = 32,
    parameter logic [XLEN-1:0] HANDLER_BASE   = 32'h8000_0000,
    parameter logic [XLEN-1:0] HANDLER_STRIDE = 32'h40
) (
    input logic             clk,
    input logic             reset,
    vx_hw_itr_ctrl_if.slave bus
);

    localparam int WID_W = (NUM_WARPS > 1) ? $clog2(NUM_WARPS) : 1;
    localparam int SRC_W = (NUM_SRCS > 1) ? $clog2(NUM_SRCS) : 1;

    typedef enum logic [1:0] {
        WARP_IDLE    = 2'd0,
        WARP_OFFERED = 2'd1,
        WARP_HANDLER = 2'd2
    } warp_state_e;

    // Per-warp context
    warp_state_e          state_q  [NUM_WARPS];
    warp_state_e          state_d  [NUM_WARPS];
    logic [NUM_SRCS-1:0]  pend_q   [NUM_WARPS];
    logic [NUM_SRCS-1:0]  pend_d   [NUM_WARPS];
    logic [XLEN-1:0]      ret_pc_q [NUM_WARPS];
    logic [XLEN-1:0]      ret_pc_d [NUM_WARPS];

    // Arbitration pointer
    logic [WID_W-1:0]     rr_q, rr_d;

    // Registered offer
    logic                 take_valid_q, take_valid_d;
    logic [WID_W-1:0]     take_wid_q, take_wid_d;
    logic [SRC_W-1:0]     take_src_q, take_src_d;
    logic [XLEN-1:0]      take_pc_q, take_pc_d;

    // Registered return results
    logic                 resume_valid_q, resume_valid_d;
    logic [WID_W-1:0]     resume_wid_q, resume_wid_d;
    logic [XLEN-1:0]      resume_pc_q, resume_pc_d;
    logic                 ret_err_q, ret_err_d;

    // Registered status views
    logic [NUM_WARPS-1:0] in_handler_q, in_handler_d;
    logic [NUM_WARPS-1:0] pending_q, pending_d;

    // Selection results
    logic [NUM_WARPS-1:0] eligible;
    logic                 sel_found;
    logic [WID_W-1:0]     sel_wid;
    logic                 src_found;
    logic [SRC_W-1:0]     sel_src;
    logic                 accept;

    // A warp may be offered only when no other offer is outstanding, so the
    // take payload stays frozen until the scheduler accepts it.
    always_comb begin
        eligible = '0;
        for (int w = 0; w < NUM_WARPS; w++) begin
            eligible[w] = (state_q[w] == WARP_IDLE) && bus.itr_enable[w] &&
                          (|pend_q[w]) && !take_valid_q;
        end
    end

    // Round-robin search starting at rr (wrapping), then lowest pending
    // source inside the winning warp. Both searches run on registered
    // pending bits, so a request is offered at the earliest one edge later.
    always_comb begin
        int cand;
        cand      = 0;
        sel_found = 1'b0;
        sel_wid   = '0;
        for (int i = 0; i < NUM_WARPS; i++) begin
            cand = (int'(rr_q) + i) % NUM_WARPS;
            if (!sel_found && eligible[cand]) begin
                sel_found = 1'b1;
                sel_wid   = WID_W'(cand);
            end
        end

        src_found = 1'b0;
        sel_src   = '0;
        for (int s = 0; s < NUM_SRCS; s++) begin
            if (!src_found && pend_q[sel_wid][s]) begin
                src_found = 1'b1;
                sel_src   = SRC_W'(s);
            end
        end
    end

    // Next-state logic for every warp context, the offer and the return
    // path. Order matters: the accept clears its pending bit before the
    // incoming request is applied, so a request hitting the same bit in the
    // same cycle survives. An accept and a return can only target different
    // warps (the accepted warp is OFFERED, not HANDLER), so both are applied.
    always_comb begin
        state_d        = state_q;
        pend_d         = pend_q;
        ret_pc_d       = ret_pc_q;
        rr_d           = rr_q;
        take_valid_d   = take_valid_q;
        take_wid_d     = take_wid_q;
        take_src_d     = take_src_q;
        take_pc_d      = take_pc_q;
        resume_valid_d = 1'b0;
        resume_wid_d   = resume_wid_q;
        resume_pc_d    = resume_pc_q;
        ret_err_d      = 1'b0;
        in_handler_d   = '0;
        pending_d      = '0;

        accept = take_valid_q && bus.take_ready;

        if (accept) begin
            ret_pc_d[take_wid_q]             = bus.take_ret_pc;
            pend_d[take_wid_q][take_src_q]   = 1'b0;
            state_d[take_wid_q]              = WARP_HANDLER;
            take_valid_d                     = 1'b0;
            if (int'(take_wid_q) == NUM_WARPS - 1) begin
                rr_d = '0;
            end else begin
                rr_d = take_wid_q + 1'b1;
            end
        end

        if (bus.ret_valid) begin
            if (state_q[bus.ret_wid] == WARP_HANDLER) begin
                resume_valid_d        = 1'b1;
                resume_wid_d          = bus.ret_wid;
                resume_pc_d           = ret_pc_q[bus.ret_wid];
                state_d[bus.ret_wid]  = WARP_IDLE;
            end else begin
                ret_err_d = 1'b1;
            end
        end

        // sel_found implies no offer is outstanding, so it never collides
        // with an accept in the same cycle.
        if (sel_found) begin
            take_valid_d     = 1'b1;
            take_wid_d       = sel_wid;
            take_src_d       = sel_src;
            take_pc_d        = HANDLER_BASE + XLEN'(sel_src) * HANDLER_STRIDE;
            state_d[sel_wid] = WARP_OFFERED;
        end

        if (bus.itr_req_valid) begin
            pend_d[bus.itr_req_wid][bus.itr_req_src] = 1'b1;
        end

        for (int w = 0; w < NUM_WARPS; w++) begin
            in_handler_d[w] = (state_d[w] == WARP_HANDLER);
            pending_d[w]    = |pend_d[w];
        end
    end

    // State register. Reset drops everything at once, including an
    // outstanding offer and the saved return PCs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int w = 0; w < NUM_WARPS; w++) begin
                state_q[w]  <= WARP_IDLE;
                pend_q[w]   <= '0;
                ret_pc_q[w] <= '0;
            end
            rr_q           <= '0;
            take_valid_q   <= 1'b0;
            take_wid_q     <= '0;
            take_src_q     <= '0;
            take_pc_q      <= '0;
            resume_valid_q <= 1'b0;
            resume_wid_q   <= '0;
            resume_pc_q    <= '0;
            ret_err_q      <= 1'b0;
            in_handler_q   <= '0;
            pending_q      <= '0;
        end else begin
            for (int w = 0; w < NUM_WARPS; w++) begin
                state_q[w]  <= state_d[w];
                pend_q[w]   <= pend_d[w];
                ret_pc_q[w] <= ret_pc_d[w];
            end
            rr_q           <= rr_d;
            take_valid_q   <= take_valid_d;
            take_wid_q     <= take_wid_d;
            take_src_q     <= take_src_d;
            take_pc_q      <= take_pc_d;
            resume_valid_q <= resume_valid_d;
            resume_wid_q   <= resume_wid_d;
            resume_pc_q    <= resume_pc_d;
            ret_err_q      <= ret_err_d;
            in_handler_q   <= in_handler_d;
            pending_q      <= pending_d;
        end
    end

    assign bus.take_valid   = take_valid_q;
    assign bus.take_wid     = take_wid_q;
    assign bus.take_src     = take_src_q;
    assign bus.take_pc      = take_pc_q;
    assign bus.resume_valid = resume_valid_q;
    assign bus.resume_wid   = resume_wid_q;
    assign bus.resume_pc    = resume_pc_q;
    assign bus.ret_err      = ret_err_q;
    assign bus.in_handler   = in_handler_q;
    assign bus.pending      = pending_q;

endmodule

// File: tb/tb_vx_hw_itr_ctrl.sv
// ---------------------------------------------------------------------------
// tb_vx_hw_itr_ctrl
//
// Scoreboard bench for vx_hw_itr_ctrl. Expected offers are queued by the
// stimulus; a negedge monitor pops them on every accepted offer, tracks
// which warps are in a handler with which saved PC, predicts the result of
// each return, and checks resume/error pulses against that prediction.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_vx_hw_itr_ctrl;

    localparam int NUM_WARPS = 4;
    localparam int NUM_SRCS  = 4;
    localparam int XLEN      = 32;
    localparam int WID_W     = 2;
    localparam int SRC_W     = 2;

    logic clk   = 1'b0;
    logic reset = 1'b0;

    // Free-running clock, 10 ns period
    always #5 clk = ~clk;

    vx_hw_itr_ctrl_if #(
        .NUM_WARPS(NUM_WARPS),
        .NUM_SRCS (NUM_SRCS),
        .XLEN     (XLEN)
    ) bus ();

    vx_hw_itr_ctrl #(
        .NUM_WARPS     (NUM_WARPS),
        .NUM_SRCS      (NUM_SRCS),
        .XLEN          (XLEN),
        .HANDLER_BASE  (32'h8000_0000),
        .HANDLER_STRIDE(32'h40)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    typedef struct {
        logic [WID_W-1:0] wid;
        logic [SRC_W-1:0] src;
        logic [XLEN-1:0]  pc;
    } take_exp_t;

    typedef struct {
        logic [WID_W-1:0] wid;
        logic [XLEN-1:0]  pc;
    } resume_exp_t;

    take_exp_t            take_q[$];
    resume_exp_t          resume_q[$];
    take_exp_t            mon_take;
    resume_exp_t          mon_res;
    int                   err_expected = 0;
    logic [NUM_WARPS-1:0] model_hdl = '0;
    logic [XLEN-1:0]      model_ret_pc [NUM_WARPS];

    int vector_count     = 0;
    int miscompare_count = 0;

    // Single comparison point: counts every check and reports mismatches
    task automatic checkOutput(input string tag, input logic [63:0] actual,
                               input logic [63:0] expected);
        vector_count++;
        if (actual !== expected) begin
            miscompare_count++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One-cycle interrupt request
    task automatic applyStimulus(input int w, input int s);
        bus.itr_req_valid = 1'b1;
        bus.itr_req_wid   = WID_W'(w);
        bus.itr_req_src   = SRC_W'(s);
        tick();
        bus.itr_req_valid = 1'b0;
    endtask

    task automatic expect_take(input int w, input int s, input logic [XLEN-1:0] pc);
        take_exp_t e;
        e.wid = WID_W'(w);
        e.src = SRC_W'(s);
        e.pc  = pc;
        take_q.push_back(e);
    endtask

    // One-cycle handler return; the monitor predicts its outcome
    task automatic send_ret(input int w);
        bus.ret_valid = 1'b1;
        bus.ret_wid   = WID_W'(w);
        tick();
        bus.ret_valid = 1'b0;
    endtask

    task automatic wait_drain(input string tag, input int budget);
        int n;
        n = 0;
        while ((take_q.size() != 0 || resume_q.size() != 0) && n < budget) begin
            tick();
            n++;
        end
        checkOutput(tag, 64'(take_q.size() + resume_q.size()), 64'd0);
    endtask

    task automatic wait_take(input string tag, input int budget);
        int n;
        n = 0;
        while (!bus.take_valid && n < budget) begin
            tick();
            n++;
        end
        checkOutput(tag, 64'(bus.take_valid), 64'd1);
    endtask

    task automatic watch_no_take(input string tag, input int cycles);
        logic seen;
        seen = 1'b0;
        for (int i = 0; i < cycles; i++) begin
            tick();
            seen = seen | bus.take_valid;
        end
        checkOutput(tag, 64'(seen), 64'd0);
    endtask

    // Scoreboard monitor: samples on the falling edge, away from the
    // active edge, and owns the warp handler model.
    always @(negedge clk) begin
        if (!reset) begin
            model_hdl = '0;
            for (int w = 0; w < NUM_WARPS; w++) model_ret_pc[w] = '0;
        end else begin
            if (bus.take_valid && bus.take_ready) begin
                if (take_q.size() == 0) begin
                    checkOutput("take_unexpected", 64'd1, 64'd0);
                end else begin
                    mon_take = take_q.pop_front();
                    checkOutput("take_wid", 64'(bus.take_wid), 64'(mon_take.wid));
                    checkOutput("take_src", 64'(bus.take_src), 64'(mon_take.src));
                    checkOutput("take_pc",  64'(bus.take_pc),  64'(mon_take.pc));
                end
                model_hdl[bus.take_wid]    = 1'b1;
                model_ret_pc[bus.take_wid] = bus.take_ret_pc;
            end
            if (bus.resume_valid) begin
                if (resume_q.size() == 0) begin
                    checkOutput("resume_unexpected", 64'd1, 64'd0);
                end else begin
                    mon_res = resume_q.pop_front();
                    checkOutput("resume_wid", 64'(bus.resume_wid), 64'(mon_res.wid));
                    checkOutput("resume_pc",  64'(bus.resume_pc),  64'(mon_res.pc));
                end
            end
            if (bus.ret_err) begin
                checkOutput("ret_err_expected", 64'(err_expected > 0), 64'd1);
                if (err_expected > 0) err_expected--;
            end
            if (bus.ret_valid) begin
                if (model_hdl[bus.ret_wid]) begin
                    mon_res.wid = bus.ret_wid;
                    mon_res.pc  = model_ret_pc[bus.ret_wid];
                    resume_q.push_back(mon_res);
                    model_hdl[bus.ret_wid] = 1'b0;
                end else begin
                    err_expected++;
                end
            end
        end
    end

    // Hard stop in case something wedges despite the bounded waits
    initial begin
        #100000;
        $display("[TB] FAIL watchdog: run exceeded time limit");
        $fatal(1, "[TB] watchdog");
    end

    // Directed scenarios
    initial begin
        bus.itr_req_valid = 1'b0;
        bus.itr_req_wid   = '0;
        bus.itr_req_src   = '0;
        bus.itr_enable    = '1;
        bus.take_ready    = 1'b0;
        bus.take_ret_pc   = '0;
        bus.ret_valid     = 1'b0;
        bus.ret_wid       = '0;

        // Reset values
        #3;
        checkOutput("rst_take_valid",   64'(bus.take_valid),   64'd0);
        checkOutput("rst_take_pc",      64'(bus.take_pc),      64'd0);
        checkOutput("rst_resume_valid", 64'(bus.resume_valid), 64'd0);
        checkOutput("rst_resume_pc",    64'(bus.resume_pc),    64'd0);
        checkOutput("rst_ret_err",      64'(bus.ret_err),      64'd0);
        checkOutput("rst_in_handler",   64'(bus.in_handler),   64'd0);
        checkOutput("rst_pending",      64'(bus.pending),      64'd0);
        #20;
        reset = 1'b1;
        tick();

        // Basic request, offer latency, accept and return
        bus.take_ready  = 1'b1;
        bus.take_ret_pc = 32'h1004;
        expect_take(2, 3, 32'h8000_00C0);
        applyStimulus(2, 3);
        checkOutput("t1_pending",       64'(bus.pending),    64'h4);
        checkOutput("t1_no_early_take", 64'(bus.take_valid), 64'd0);
        tick();
        checkOutput("t1_take_latency",  64'(bus.take_valid), 64'd1);
        tick();
        checkOutput("t1_take_drop",     64'(bus.take_valid), 64'd0);
        checkOutput("t1_in_handler",    64'(bus.in_handler), 64'h4);
        checkOutput("t1_pending_clr",   64'(bus.pending),    64'd0);
        wait_drain("t1_take_drain", 10);
        bus.take_ready = 1'b0;
        send_ret(2);
        checkOutput("t1_resume_valid",  64'(bus.resume_valid), 64'd1);
        checkOutput("t1_resume_pc",     64'(bus.resume_pc),    64'h1004);
        checkOutput("t1_in_handler_clr", 64'(bus.in_handler),  64'd0);
        wait_drain("t1_resume_drain", 10);
        checkOutput("t1_resume_pulse",  64'(bus.resume_valid), 64'd0);

        // Enable gating, then lowest source first
        bus.itr_enable = 4'b1101;
        applyStimulus(1, 2);
        applyStimulus(1, 0);
        watch_no_take("t2_enable_gate", 4);
        checkOutput("t2_pending", 64'(bus.pending), 64'h2);
        bus.take_ready  = 1'b1;
        bus.take_ret_pc = 32'h2000;
        expect_take(1, 0, 32'h8000_0000);
        bus.itr_enable  = '1;
        wait_drain("t2_first_drain", 10);
        bus.take_ret_pc = 32'h2100;
        expect_take(1, 2, 32'h8000_0080);
        send_ret(1);
        wait_drain("t2_second_drain", 20);
        send_ret(1);
        wait_drain("t2_ret_drain", 10);

        // No nesting: request while in handler waits for the return
        bus.take_ret_pc = 32'h3000;
        expect_take(0, 1, 32'h8000_0040);
        applyStimulus(0, 1);
        wait_drain("t4_first_drain", 10);
        bus.take_ready = 1'b0;
        applyStimulus(0, 3);
        watch_no_take("t4_no_nesting", 4);
        checkOutput("t4_pending", 64'(bus.pending), 64'h1);
        send_ret(0);
        checkOutput("t4_resume",      64'(bus.resume_valid), 64'd1);
        checkOutput("t4_no_take_yet", 64'(bus.take_valid),   64'd0);
        tick();
        checkOutput("t4_take_after_resume", 64'(bus.take_valid), 64'd1);
        expect_take(0, 3, 32'h8000_00C0);
        bus.take_ret_pc = 32'h3100;
        bus.take_ready  = 1'b1;
        wait_drain("t4_second_drain", 10);
        send_ret(0);
        wait_drain("t4_ret_drain", 10);

        // Return from an idle warp
        bus.take_ready = 1'b0;
        send_ret(3);
        checkOutput("t5_ret_err",    64'(bus.ret_err),      64'd1);
        checkOutput("t5_no_resume",  64'(bus.resume_valid), 64'd0);
        checkOutput("t5_in_handler", 64'(bus.in_handler),   64'd0);
        tick();
        checkOutput("t5_err_pulse",  64'(bus.ret_err),      64'd0);

        // Set wins over an accept clearing the same pending bit
        applyStimulus(1, 1);
        wait_take("t7_take_wait", 10);
        expect_take(1, 1, 32'h8000_0040);
        bus.take_ret_pc   = 32'h6000;
        bus.take_ready    = 1'b1;
        bus.itr_req_valid = 1'b1;
        bus.itr_req_wid   = 2'd1;
        bus.itr_req_src   = 2'd1;
        tick();
        bus.itr_req_valid = 1'b0;
        checkOutput("t7_pending_kept", 64'(bus.pending),    64'h2);
        checkOutput("t7_in_handler",   64'(bus.in_handler), 64'h2);
        expect_take(1, 1, 32'h8000_0040);
        send_ret(1);
        wait_drain("t7_second_drain", 20);
        send_ret(1);
        wait_drain("t7_ret_drain", 10);

        // Reset in the middle of an offer with a warp in its handler
        bus.take_ready = 1'b0;
        applyStimulus(1, 0);
        wait_take("t6_take_wait1", 10);
        expect_take(1, 0, 32'h8000_0000);
        bus.take_ret_pc = 32'h4000;
        bus.take_ready  = 1'b1;
        tick();
        bus.take_ready  = 1'b0;
        applyStimulus(2, 1);
        wait_take("t6_take_wait2", 10);
        checkOutput("t6_pre_in_handler", 64'(bus.in_handler), 64'h2);
        #2;
        reset = 1'b0;
        #1;
        checkOutput("t6_take_valid", 64'(bus.take_valid), 64'd0);
        checkOutput("t6_take_pc",    64'(bus.take_pc),    64'd0);
        checkOutput("t6_take_wid",   64'(bus.take_wid),   64'd0);
        checkOutput("t6_in_handler", 64'(bus.in_handler), 64'd0);
        checkOutput("t6_pending",    64'(bus.pending),    64'd0);
        tick();
        tick();
        #2;
        reset = 1'b1;
        watch_no_take("t6_no_offer_after_reset", 5);
        send_ret(1);
        checkOutput("t6_ret_err_after_reset", 64'(bus.ret_err), 64'd1);
        tick();

        // Round-robin order 0, 1, 3 from a fresh pointer, then wrap to 0
        bus.itr_enable = '0;
        applyStimulus(3, 2);
        applyStimulus(1, 1);
        applyStimulus(0, 0);
        checkOutput("t3_pending", 64'(bus.pending), 64'hB);
        expect_take(0, 0, 32'h8000_0000);
        expect_take(1, 1, 32'h8000_0040);
        expect_take(3, 2, 32'h8000_0080);
        bus.take_ready  = 1'b1;
        bus.take_ret_pc = 32'h5000;
        bus.itr_enable  = '1;
        wait_drain("t3_rr_drain", 30);
        send_ret(0);
        send_ret(1);
        send_ret(3);
        wait_drain("t3_ret_drain", 10);
        checkOutput("t3_in_handler", 64'(bus.in_handler), 64'd0);
        bus.itr_enable  = '0;
        applyStimulus(2, 0);
        applyStimulus(0, 3);
        expect_take(0, 3, 32'h8000_00C0);
        expect_take(2, 0, 32'h8000_0000);
        bus.take_ret_pc = 32'h5100;
        bus.itr_enable  = '1;
        wait_drain("t3_wrap_drain", 20);
        send_ret(0);
        send_ret(2);
        wait_drain("t3_wrap_ret_drain", 10);

        tick();
        tick();
        checkOutput("err_left", 64'(err_expected), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vector_count, miscompare_count);
        $finish;
    end

endmodule
